// File: rtl/mem_sequencer.sv
// Memory-block bus-master sequencer: expands one-word requests into per-cycle
// address/data select codes and address-counter strobes for the memory block.
module mem_sequencer #(
  parameter logic [2:0] A_IDLE = 3'd7,
  parameter logic [3:0] C_IDLE = 4'd15,
  parameter logic [2:0] A_TX   = 3'd0,
  parameter logic [2:0] A_SDP  = 3'd1,
  parameter logic [2:0] A_SP   = 3'd3,
  parameter logic [2:0] A_PC   = 3'd5,
  parameter logic [3:0] C_IR   = 4'd8,
  parameter logic [3:0] C_MEM  = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [3:0] req_reg,
  input  logic [3:0] req_count,
  input  logic       hold,
  output logic [2:0] addroutctl,
  output logic [2:0] addrloadctl,
  output logic [3:0] outctl,
  output logic [3:0] loadctl,
  output logic       acincn,
  output logic       acdecn,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_RDTX  = 3'd3;
  localparam logic [2:0] OP_WRTX  = 3'd4;
  localparam logic [2:0] OP_RDSDP = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_P0, S_P1, S_Q0, S_R0, S_W0, S_B, S_DN
  } state_e;

  typedef struct packed {
    logic [2:0] addr;
    logic [3:0] outc;
    logic [3:0] loadc;
    logic       inc_n;
    logic       dec_n;
    logic       busy;
    logic       done;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{addr: A_IDLE, outc: C_IDLE, loadc: C_IDLE,
                                inc_n: 1'b1, dec_n: 1'b1, busy: 1'b0, done: 1'b0};

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] num_q, num_d;
  logic [3:0] reg_q, reg_d;
  logic       err_q, err_d;
  ctl_t       ctl_q, ctl_d;

  logic accept, uses_reg, is_write, bad;

  assign req_ready = (state_q == S_IDLE) && !hold;
  assign accept    = req_valid && req_ready;
  assign uses_reg  = (req_op != OP_FETCH);
  assign is_write  = (req_op == OP_PUSH) || (req_op == OP_WRTX);
  assign bad       = (req_op > OP_RDSDP)
                   || (uses_reg && (req_reg == C_MEM || req_reg == C_IDLE))
                   || (is_write && req_reg == C_IR);

  // Next state: hold freezes everything; rejected requests leave the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    reg_d   = reg_q;
    err_d   = err_q && hold;
    if (accept) begin
      if (bad) begin
        err_d = 1'b1;
      end else begin
        reg_d = req_reg;
        num_d = {req_count == 4'd0, req_count};
        cnt_d = 5'd0;
        case (req_op)
          OP_FETCH: state_d = S_F0;
          OP_PUSH:  state_d = S_P0;
          OP_POP:   state_d = S_Q0;
          OP_RDTX:  state_d = S_R0;
          OP_WRTX:  state_d = S_W0;
          default:  state_d = S_B;
        endcase
      end
    end else if (!hold) begin
      case (state_q)
        S_F0, S_P1, S_Q0, S_R0, S_W0: state_d = S_DN;
        S_P0: state_d = S_P1;
        S_B: begin
          if (cnt_q + 5'd1 == num_q) begin
            state_d = S_DN;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_DN:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Decode the upcoming state so the control codes come straight from flops.
  always_comb begin
    ctl_d = CTL_IDLE;
    case (state_d)
      S_F0: begin
        ctl_d.addr = A_PC; ctl_d.outc = C_MEM; ctl_d.loadc = C_IR; ctl_d.inc_n = 1'b0;
      end
      S_P0: begin
        ctl_d.addr = A_SP; ctl_d.dec_n = 1'b0;
      end
      S_P1: begin
        ctl_d.addr = A_SP; ctl_d.outc = reg_d; ctl_d.loadc = C_MEM;
      end
      S_Q0: begin
        ctl_d.addr = A_SP; ctl_d.outc = C_MEM; ctl_d.loadc = reg_d; ctl_d.inc_n = 1'b0;
      end
      S_R0: begin
        ctl_d.addr = A_TX; ctl_d.outc = C_MEM; ctl_d.loadc = reg_d;
      end
      S_W0: begin
        ctl_d.addr = A_TX; ctl_d.outc = reg_d; ctl_d.loadc = C_MEM;
      end
      S_B: begin
        ctl_d.addr = A_SDP; ctl_d.outc = C_MEM; ctl_d.loadc = reg_d; ctl_d.inc_n = 1'b0;
      end
      S_DN:    ctl_d.done = 1'b1;
      default: ctl_d = CTL_IDLE;
    endcase
    ctl_d.busy = (state_d != S_IDLE) && (state_d != S_DN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      num_q   <= 5'd0;
      reg_q   <= C_IDLE;
      err_q   <= 1'b0;
      ctl_q   <= CTL_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      reg_q   <= reg_d;
      err_q   <= err_d;
      ctl_q   <= ctl_d;
    end
  end

  // A frozen beat must never reach the bus, so hold masks the registered codes.
  assign addroutctl  = hold ? A_IDLE : ctl_q.addr;
  assign addrloadctl = A_IDLE;
  assign outctl      = hold ? C_IDLE : ctl_q.outc;
  assign loadctl     = hold ? C_IDLE : ctl_q.loadc;
  assign acincn      = hold ? 1'b1   : ctl_q.inc_n;
  assign acdecn      = hold ? 1'b1   : ctl_q.dec_n;
  assign busy        = ctl_q.busy;
  assign done        = ctl_q.done && !hold;
  assign err         = err_q && !hold;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: directed vector table, hand sequences for burst and
// hold corners, and random traffic checked against a per-beat queue model.
module tb_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, hold;
  logic [2:0] req_op, addroutctl, addrloadctl;
  logic [3:0] req_reg, req_count, outctl, loadctl;
  logic       acincn, acdecn, busy, done, err;

  always #5 clk = ~clk;

  mem_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_reg(req_reg), .req_count(req_count), .hold(hold),
    .addroutctl(addroutctl), .addrloadctl(addrloadctl), .outctl(outctl),
    .loadctl(loadctl), .acincn(acincn), .acdecn(acdecn), .busy(busy),
    .done(done), .err(err)
  );

  typedef struct packed {
    logic [2:0] al;
    logic [2:0] a;
    logic [3:0] o;
    logic [3:0] l;
    logic       inc_n;
    logic       dec_n;
    logic       busy;
    logic       done;
    logic       err;
    logic       ready;
  } obs_t;

  typedef struct packed {
    logic       r, v;
    logic [2:0] op;
    logic [3:0] rg, cn;
    logic       h;
    obs_t       exp;
  } vec_t;

  int   tests = 0, fails = 0;
  obs_t obs_last;
  obs_t mq[$];
  bit   err_pend = 0;

  function automatic obs_t o_(input logic [2:0] a, input logic [3:0] o, l,
                              input logic inc, dec, bz, dn, er, rdy);
    o_ = '{3'd7, a, o, l, inc, dec, bz, dn, er, rdy};
  endfunction

  function automatic obs_t idl(input logic bz, dn, er, rdy);
    idl = o_(3'd7, 4'd15, 4'd15, 1'b1, 1'b1, bz, dn, er, rdy);
  endfunction

  function automatic vec_t row(input logic r, v, input logic [2:0] op,
                               input logic [3:0] rg, cn, input logic h, input obs_t e);
    row = '{r, v, op, rg, cn, h, e};
  endfunction

  task automatic chk_obs(input string nm, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (al a o l inc dec busy done err rdy)", nm, got, exp);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Reference: an accepted request becomes a list of expected bus beats plus a done cycle.
  function automatic obs_t beat(input logic [2:0] a, input logic [3:0] o, l, input logic inc, dec);
    beat = o_(a, o, l, inc, dec, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic bit is_bad(input logic [2:0] op, input logic [3:0] rg);
    is_bad = (op > 3'd5) || (op != 3'd0 && (rg == 4'd9 || rg == 4'd15))
          || ((op == 3'd1 || op == 3'd4) && rg == 4'd8);
  endfunction

  function automatic obs_t model_exp(input logic h);
    obs_t e;
    if (mq.size() != 0) begin
      e = h ? idl(mq[0].busy, 1'b0, 1'b0, 1'b0) : mq[0];
    end else begin
      e = idl(1'b0, 1'b0, err_pend && !h, !h);
    end
    return e;
  endfunction

  function automatic void model_step(input logic r, v, input logic [2:0] op,
                                     input logic [3:0] rg, cn, input logic h);
    int n;
    bit was_empty = (mq.size() == 0);
    if (r) begin
      mq.delete();
      err_pend = 0;
      return;
    end
    if (!h) err_pend = 0;
    if (!was_empty) begin
      if (!h) void'(mq.pop_front());
    end else if (v && !h) begin
      if (is_bad(op, rg)) err_pend = 1;
      else begin
        case (op)
          3'd0: mq.push_back(beat(3'd5, 4'd9, 4'd8, 1'b0, 1'b1));
          3'd1: begin
            mq.push_back(beat(3'd3, 4'd15, 4'd15, 1'b1, 1'b0));
            mq.push_back(beat(3'd3, rg, 4'd9, 1'b1, 1'b1));
          end
          3'd2: mq.push_back(beat(3'd3, 4'd9, rg, 1'b0, 1'b1));
          3'd3: mq.push_back(beat(3'd0, 4'd9, rg, 1'b1, 1'b1));
          3'd4: mq.push_back(beat(3'd0, rg, 4'd9, 1'b1, 1'b1));
          default: begin
            n = (cn == 4'd0) ? 16 : int'(cn);
            for (int k = 0; k < n; k++) mq.push_back(beat(3'd1, 4'd9, rg, 1'b0, 1'b1));
          end
        endcase
        mq.push_back(idl(1'b0, 1'b1, 1'b0, 1'b0));
      end
    end
  endfunction

  // One clock: drive, sample at negedge, compare with model and bus rules, advance.
  task automatic cyc(input logic r, v, input logic [2:0] op, input logic [3:0] rg, cn, input logic h);
    obs_t e;
    bit   ctr;
    rst = r; req_valid = v; req_op = op; req_reg = rg; req_count = cn; hold = h;
    @(negedge clk);
    obs_last = '{addrloadctl, addroutctl, outctl, loadctl, acincn, acdecn, busy, done, err, req_ready};
    e = model_exp(h);
    chk_obs("model", obs_last, e);
    ctr = (addroutctl == 3'd1) || (addroutctl == 3'd3) || (addroutctl == 3'd5);
    tests++;
    if ((!acincn && !acdecn) || (outctl == 4'd9 && loadctl == 4'd9) || ((!acincn || !acdecn) && !ctr)) begin
      fails++;
      $display("FAIL bus_rule got a=%0d o=%0d l=%0d inc=%b dec=%b", addroutctl, outctl, loadctl, acincn, acdecn);
    end
    @(posedge clk);
    model_step(r, v, op, rg, cn, h);
    #1;
  endtask

  // RD_SDP with an optional hold window counted in cycles after accept.
  task automatic sdp_run(input logic [3:0] cn, input int hs, hl, input int exp_beats, input string nm);
    int  beats = 0;
    bit  seen = 0;
    logic h;
    cyc(1'b0, 1'b1, 3'd5, 4'd3, cn, 1'b0);
    for (int k = 0; k < 60 && !seen; k++) begin
      h = (k >= hs) && (k < hs + hl);
      cyc(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, h);
      if (h) chk({nm, "_hold_idle"}, int'(addroutctl), 7);
      else if (obs_last.done) seen = 1;
      else if (obs_last.a == 3'd1 && obs_last.o == 4'd9 && obs_last.l == 4'd3 && !obs_last.inc_n) beats++;
    end
    chk({nm, "_done"}, int'(seen), 1);
    chk({nm, "_beats"}, beats, exp_beats);
  endtask

  vec_t vecs[31];

  initial begin
    vecs[0]  = row(1, 0, 0, 0, 0, 0, idl(0, 0, 0, 1));
    vecs[1]  = row(0, 1, 0, 0, 0, 0, idl(0, 0, 0, 1));
    vecs[2]  = row(0, 0, 0, 0, 0, 0, o_(5, 9, 8, 0, 1, 1, 0, 0, 0));
    vecs[3]  = row(0, 0, 0, 0, 0, 0, idl(0, 1, 0, 0));
    vecs[4]  = row(0, 1, 1, 2, 0, 0, idl(0, 0, 0, 1));
    vecs[5]  = row(0, 0, 0, 0, 0, 0, o_(3, 15, 15, 1, 0, 1, 0, 0, 0));
    vecs[6]  = row(0, 0, 0, 0, 0, 0, o_(3, 2, 9, 1, 1, 1, 0, 0, 0));
    vecs[7]  = row(0, 0, 0, 0, 0, 0, idl(0, 1, 0, 0));
    vecs[8]  = row(0, 1, 6, 0, 0, 0, idl(0, 0, 0, 1));
    vecs[9]  = row(0, 0, 0, 0, 0, 0, idl(0, 0, 1, 1));
    vecs[10] = row(0, 1, 1, 9, 0, 0, idl(0, 0, 0, 1));
    vecs[11] = row(0, 0, 0, 0, 0, 0, idl(0, 0, 1, 1));
    vecs[12] = row(0, 1, 4, 8, 0, 0, idl(0, 0, 0, 1));
    vecs[13] = row(0, 0, 0, 0, 0, 0, idl(0, 0, 1, 1));
    vecs[14] = row(0, 1, 3, 8, 0, 0, idl(0, 0, 0, 1));
    vecs[15] = row(0, 0, 0, 0, 0, 0, o_(0, 9, 8, 1, 1, 1, 0, 0, 0));
    vecs[16] = row(0, 0, 0, 0, 0, 0, idl(0, 1, 0, 0));
    vecs[17] = row(0, 1, 1, 4, 0, 0, idl(0, 0, 0, 1));
    vecs[18] = row(1, 0, 0, 0, 0, 0, o_(3, 15, 15, 1, 0, 1, 0, 0, 0));
    vecs[19] = row(0, 1, 0, 0, 0, 0, idl(0, 0, 0, 1));
    vecs[20] = row(0, 0, 0, 0, 0, 0, o_(5, 9, 8, 0, 1, 1, 0, 0, 0));
    vecs[21] = row(0, 0, 0, 0, 0, 0, idl(0, 1, 0, 0));
    vecs[22] = row(0, 0, 0, 0, 0, 1, idl(0, 0, 0, 0));
    vecs[23] = row(0, 1, 2, 5, 0, 0, idl(0, 0, 0, 1));
    vecs[24] = row(0, 0, 0, 0, 0, 0, o_(3, 9, 5, 0, 1, 1, 0, 0, 0));
    vecs[25] = row(0, 0, 0, 0, 0, 0, idl(0, 1, 0, 0));
    vecs[26] = row(0, 0, 0, 0, 0, 0, idl(0, 0, 0, 1));
    vecs[27] = row(0, 1, 7, 0, 0, 0, idl(0, 0, 0, 1));
    vecs[28] = row(0, 0, 0, 0, 0, 1, idl(0, 0, 0, 0));
    vecs[29] = row(0, 0, 0, 0, 0, 0, idl(0, 0, 1, 1));
    vecs[30] = row(0, 0, 0, 0, 0, 0, idl(0, 0, 0, 1));

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_reg = '0; req_count = '0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].v, vecs[i].op, vecs[i].rg, vecs[i].cn, vecs[i].h);
      chk_obs($sformatf("vec%0d", i), obs_last, vecs[i].exp);
    end

    sdp_run(4'd0, 100, 0, 16, "sdp16");
    cyc(0, 0, 0, 0, 0, 0);
    sdp_run(4'd1, 100, 0, 1, "sdp1");
    cyc(0, 0, 0, 0, 0, 0);
    sdp_run(4'd5, 2, 4, 5, "sdp5_hold");
    cyc(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rg;
      rg = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
          rg, 4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
